// File: rtl/snes_multi_if.sv
// rtl/snes_multi_if.sv - multi-pad SNES controller poller with press/release events and presence detection
module snes_multi_if #(
    parameter int NUM_PADS  = 2,
    parameter int N_BITS    = 16,
    parameter int PRSC_DIV  = 900,
    parameter int GAP_TICKS = 700,
    parameter int DETECT    = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_enable,
    input  logic [NUM_PADS-1:0]        i_snes_data,
    output logic                       o_snes_clk,
    output logic                       o_snes_latch,
    output logic [NUM_PADS*N_BITS-1:0] o_btn_state,
    output logic [NUM_PADS*N_BITS-1:0] o_btn_press,
    output logic [NUM_PADS*N_BITS-1:0] o_btn_release,
    output logic                       o_btn_state_en,
    output logic [NUM_PADS-1:0]        o_present,
    output logic                       o_busy
);

    localparam int W  = NUM_PADS * N_BITS;
    localparam int PW = $clog2(PRSC_DIV);
    localparam int BW = $clog2(N_BITS);
    localparam int GW = $clog2(GAP_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_SAMPLE, S_RISE, S_PRES_LO, S_PRES_HI, S_DONE, S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       prsc_q, prsc_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
    logic                clk_q, clk_d;
    logic                latch_q, latch_d;
    logic [W-1:0]        shift_q, shift_d;
    logic [NUM_PADS-1:0] pres_cap_q, pres_cap_d;
    logic [W-1:0]        state_w_q, state_w_d;
    logic [W-1:0]        press_q, press_d;
    logic [W-1:0]        release_q, release_d;
    logic [NUM_PADS-1:0] present_q, present_d;
    logic                en_q, en_d;

    logic                tick;
    logic [NUM_PADS-1:0] pres_eff;
    logic [W-1:0]        new_w;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            prsc_q     <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            clk_q      <= 1'b1;
            latch_q    <= 1'b0;
            shift_q    <= '0;
            pres_cap_q <= '0;
            state_w_q  <= '0;
            press_q    <= '0;
            release_q  <= '0;
            present_q  <= '0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            prsc_q     <= prsc_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            clk_q      <= clk_d;
            latch_q    <= latch_d;
            shift_q    <= shift_d;
            pres_cap_q <= pres_cap_d;
            state_w_q  <= state_w_d;
            press_q    <= press_d;
            release_q  <= release_d;
            present_q  <= present_d;
            en_q       <= en_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        clk_d      = clk_q;
        latch_d    = latch_q;
        shift_d    = shift_q;
        pres_cap_d = pres_cap_q;
        state_w_d  = state_w_q;
        press_d    = press_q;
        release_d  = release_q;
        present_d  = present_q;
        en_d       = 1'b0;

        tick   = (prsc_q == PW'(PRSC_DIV - 1));
        prsc_d = tick ? '0 : prsc_q + PW'(1);

        // Without detection every pad is treated as connected.
        pres_eff = (DETECT != 0) ? pres_cap_q : '1;
        for (int p = 0; p < NUM_PADS; p++) begin
            new_w[p*N_BITS +: N_BITS] = pres_eff[p] ? shift_q[p*N_BITS +: N_BITS] : '0;
        end

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (i_enable) begin
                        latch_d = 1'b1;
                        state_d = S_LATCH;
                    end
                end
                S_LATCH: begin
                    latch_d   = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = S_SAMPLE;
                end
                S_SAMPLE: begin
                    clk_d = 1'b0;
                    for (int p = 0; p < NUM_PADS; p++) begin
                        shift_d[p*N_BITS +: N_BITS] =
                            {shift_q[p*N_BITS +: N_BITS-1], ~i_snes_data[p]};
                    end
                    state_d = S_RISE;
                end
                S_RISE: begin
                    clk_d = 1'b1;
                    if (bit_cnt_q == BW'(N_BITS - 1)) begin
                        state_d = (DETECT != 0) ? S_PRES_LO : S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        state_d   = S_SAMPLE;
                    end
                end
                S_PRES_LO: begin
                    // A connected pad drives its line low once its bits are exhausted.
                    clk_d      = 1'b0;
                    pres_cap_d = ~i_snes_data;
                    state_d    = S_PRES_HI;
                end
                S_PRES_HI: begin
                    clk_d   = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    press_d   = new_w & ~state_w_q;
                    release_d = ~new_w & state_w_q;
                    state_w_d = new_w;
                    present_d = pres_eff;
                    en_d      = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end
                S_GAP: begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                    if (gap_cnt_q == GW'(GAP_TICKS - 1)) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign o_snes_clk     = clk_q;
    assign o_snes_latch   = latch_q;
    assign o_btn_state    = state_w_q;
    assign o_btn_press    = press_q;
    assign o_btn_release  = release_q;
    assign o_btn_state_en = en_q;
    assign o_present      = present_q;
    assign o_busy         = (state_q != S_IDLE) && (state_q != S_GAP);

endmodule
